relu_grad_mask: RTL and testbench

- Backward-direction counterpart of the forward ReLU stage on the systolic-array output bus.
- During the forward pass it captures a per-lane activity bitmask for each activation vector into a small mask FIFO.
- During the backward pass it pops one mask per incoming gradient vector and zeroes the gradient lanes whose forward input was negative.
- Sits between the gradient source and the weight-update datapath, using valid/ready handshakes on every side.

---
 rtl/relu_grad_mask.sv | 107 ++++++++++
 tb/tb_relu_grad_mask.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/relu_grad_mask.sv
// Backward ReLU gradient mask: records per-lane activity masks from forward vectors in a FIFO
// and applies them, in order, to incoming gradient vectors. Optional: RELU_GRAD_ZERO_INACTIVE_EN.
`timescale 1ns/1ps
module relu_grad_mask #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LANES = 64,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       fwd_valid,
  output logic                       fwd_ready,
  input  logic [LANES*WIDTH-1:0]     fwd_data,
  input  logic                       fwd_apply,
  input  logic                       bwd_valid,
  output logic                       bwd_ready,
  input  logic [LANES*WIDTH-1:0]     bwd_grad,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES*WIDTH-1:0]     out_grad,
  output logic [$clog2(DEPTH):0]     mask_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] Full = CW'(DEPTH);

  logic [LANES-1:0]       mem_q [DEPTH];
  logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]          count_q;
  logic                   out_valid_q;
  logic [LANES*WIDTH-1:0] out_grad_q;

  logic                   push, pop;
  logic [LANES-1:0]       fwd_mask;
  logic [LANES-1:0]       rd_mask;
  logic [LANES*WIDTH-1:0] grad_masked;

  // Readiness depends only on registered state (plus out_ready), never on the valids.
  assign fwd_ready  = (count_q != Full);
  assign bwd_ready  = (count_q != '0) & (~out_valid_q | out_ready);
  assign push       = fwd_valid & fwd_ready;
  assign pop        = bwd_valid & bwd_ready;
  assign mask_count = count_q;
  assign out_valid  = out_valid_q;
  assign out_grad   = out_grad_q;
  assign rd_mask    = mem_q[rd_ptr_q];

  always_comb begin
    fwd_mask = '1;
    if (fwd_apply) begin
      for (int i = 0; i < LANES; i++) begin
`ifdef RELU_GRAD_ZERO_INACTIVE_EN
        fwd_mask[i] = ~fwd_data[WIDTH*i + WIDTH - 1] & (|fwd_data[WIDTH*i +: WIDTH]);
`else
        fwd_mask[i] = ~fwd_data[WIDTH*i + WIDTH - 1];
`endif
      end
    end
  end

  always_comb begin
    grad_masked = '0;
    for (int i = 0; i < LANES; i++) begin
      grad_masked[WIDTH*i +: WIDTH] = rd_mask[i] ? bwd_grad[WIDTH*i +: WIDTH] : '0;
    end
  end

  // Mask storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_q[wr_ptr_q] <= fwd_mask;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_grad_q  <= '0;
    end else if (flush) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_grad_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (pop) begin
        out_valid_q <= 1'b1;
        out_grad_q  <= grad_masked;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_relu_grad_mask.sv
// Self-checking bench for relu_grad_mask: mask/expected-output scoreboard plus directed checks.
`timescale 1ns/1ps
module tb_relu_grad_mask;

  localparam int W  = 16;
  localparam int L  = 64;
  localparam int D  = 8;
  localparam int VW = W * L;
  typedef logic [VW-1:0] vec_t;

  logic clk, rst_n, flush;
  logic fwd_valid, fwd_ready, fwd_apply;
  logic bwd_valid, bwd_ready;
  logic out_valid, out_ready;
  vec_t fwd_data, bwd_grad, out_grad;
  logic [$clog2(D):0] mask_count;

  int n_checks = 0;
  int n_fail   = 0;
  logic [L-1:0] mask_q[$];
  vec_t         exp_q[$];

  relu_grad_mask #(.WIDTH(W), .LANES(L), .DEPTH(D)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .fwd_valid  (fwd_valid),
    .fwd_ready  (fwd_ready),
    .fwd_data   (fwd_data),
    .fwd_apply  (fwd_apply),
    .bwd_valid  (bwd_valid),
    .bwd_ready  (bwd_ready),
    .bwd_grad   (bwd_grad),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_grad   (out_grad),
    .mask_count (mask_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input vec_t obs, input vec_t exp);
    int lane;
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      lane = 0;
      for (int i = L - 1; i >= 0; i--) begin
        if (obs[W*i +: W] !== exp[W*i +: W]) lane = i;
      end
      $display("FAIL %s: lane %0d got %h expected %h", tag, lane, obs[W*lane +: W],
               exp[W*lane +: W]);
    end
  endtask

  function automatic logic [L-1:0] model_mask(input vec_t d, input logic apply);
    logic [L-1:0] m;
    logic [W-1:0] v;
    for (int i = 0; i < L; i++) begin
      v = d[W*i +: W];
`ifdef RELU_GRAD_ZERO_INACTIVE_EN
      m[i] = apply ? (!v[W-1] && (v != '0)) : 1'b1;
`else
      m[i] = apply ? !v[W-1] : 1'b1;
`endif
    end
    return m;
  endfunction

  function automatic vec_t apply_mask(input vec_t g, input logic [L-1:0] m);
    vec_t r;
    for (int i = 0; i < L; i++) r[W*i +: W] = m[i] ? g[W*i +: W] : 16'h0000;
    return r;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int i = 0; i < L; i++) v[W*i +: W] = 16'($urandom);
    return v;
  endfunction

  function automatic vec_t fill_vec(input logic [W-1:0] x);
    vec_t v;
    for (int i = 0; i < L; i++) v[W*i +: W] = x;
    return v;
  endfunction

  // Handshakes are observed mid-cycle; inputs change 1ns after the rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      mask_q.delete();
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("sb_unexpected_out", 1, 0);
        else check("sb_out_grad", out_grad, exp_q.pop_front());
      end
      if (flush) begin
        mask_q.delete();
        exp_q.delete();
      end else begin
        if (fwd_valid && fwd_ready) mask_q.push_back(model_mask(fwd_data, fwd_apply));
        if (bwd_valid && bwd_ready) begin
          if (mask_q.size() == 0) check("sb_pop_empty", 1, 0);
          else exp_q.push_back(apply_mask(bwd_grad, mask_q.pop_front()));
        end
      end
    end
  end

  task automatic drive_fwd(input vec_t d, input logic a);
    int n = 0;
    fwd_data = d; fwd_apply = a; fwd_valid = 1'b1;
    @(negedge clk);
    while (!fwd_ready && n < 50) begin n++; @(negedge clk); end
    if (!fwd_ready) check("fwd_timeout", 0, 1);
    @(posedge clk); #1;
    fwd_valid = 1'b0;
  endtask

  task automatic drive_bwd(input vec_t g);
    int n = 0;
    bwd_grad = g; bwd_valid = 1'b1;
    @(negedge clk);
    while (!bwd_ready && n < 50) begin n++; @(negedge clk); end
    if (!bwd_ready) check("bwd_timeout", 0, 1);
    @(posedge clk); #1;
    bwd_valid = 1'b0;
  endtask

  initial begin
    vec_t v, e;
    int pushes, pops, cyc;
    logic f, b;
    rst_n = 1'b0; flush = 1'b0; fwd_valid = 1'b0; fwd_apply = 1'b1; bwd_valid = 1'b0;
    out_ready = 1'b1; fwd_data = '0; bwd_grad = '0;
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_grad", out_grad, 0);
    check("rst_mask_count", mask_count, 0);
    check("rst_fwd_ready", fwd_ready, 1);
    check("rst_bwd_ready", bwd_ready, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Sign-based masking
    v = '0; v[15:0] = 16'h8001; v[31:16] = 16'h0005;
    drive_fwd(v, 1'b1);
`ifdef RELU_GRAD_ZERO_INACTIVE_EN
    e = '0; e[31:16] = 16'h0011;
`else
    e = fill_vec(16'h0011); e[15:0] = 16'h0000;
`endif
    drive_bwd(fill_vec(16'h0011));
    check("t1_out_valid", out_valid, 1);
    check("t1_out_grad", out_grad, e);

    // fwd_apply=0 stores an all-ones mask
    drive_fwd(fill_vec(16'hFFFF), 1'b0);
    drive_bwd(fill_vec(16'h1234));
    check("t2_out_grad", out_grad, fill_vec(16'h1234));
    @(posedge clk); #1;

    // Fill, then a held 9th push against one pop
    fwd_apply = 1'b1; fwd_valid = 1'b1; fwd_data = rand_vec();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); check("t3_fwd_ready_fill", fwd_ready, 1);
      @(posedge clk); #1 fwd_data = rand_vec();
    end
    @(negedge clk);
    check("t3_full_ready", fwd_ready, 0);
    check("t3_full_count", mask_count, 8);
    @(posedge clk); #1 bwd_valid = 1'b1; bwd_grad = rand_vec();
    @(negedge clk);
    check("t3_full_during_pop", fwd_ready, 0);
    check("t3_pop_ready", bwd_ready, 1);
    @(posedge clk); #1 bwd_valid = 1'b0;
    @(negedge clk);
    check("t3_count_after_pop", mask_count, 7);
    check("t3_ready_after_pop", fwd_ready, 1);
    @(posedge clk); #1 fwd_valid = 1'b0;
    @(negedge clk);
    check("t3_count_refill", mask_count, 8);

    // Output backpressure then back-to-back pops
    @(posedge clk); #1 out_ready = 1'b0; bwd_valid = 1'b1; bwd_grad = rand_vec();
    @(negedge clk); check("t4_first_pop_ready", bwd_ready, 1);
    @(posedge clk); #1 bwd_grad = rand_vec();
    repeat (3) begin
      @(negedge clk);
      check("t4_stall_bwd_ready", bwd_ready, 0);
      check("t4_stall_count", mask_count, 7);
      check("t4_stall_valid", out_valid, 1);
      if (exp_q.size() == 1) check("t4_hold_grad", out_grad, exp_q[0]);
      else check("t4_sb_size", exp_q.size(), 1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk); check("t4_b2b_ready", bwd_ready, 1);
      @(posedge clk); #1 bwd_grad = rand_vec();
    end
    bwd_valid = 1'b0;
    @(negedge clk); check("t4_count_after", mask_count, 4);
    @(posedge clk); #1;
    repeat (4) drive_bwd(rand_vec());

    // Interleaved 12/12 across pointer wrap with random backpressure
    pushes = 0; pops = 0; cyc = 0;
    fwd_valid = 1'b1; fwd_data = rand_vec(); fwd_apply = 1'($urandom);
    bwd_valid = 1'b1; bwd_grad = rand_vec();
    while ((pushes < 12 || pops < 12) && cyc < 300) begin
      @(negedge clk);
      f = fwd_valid && fwd_ready;
      b = bwd_valid && bwd_ready;
      @(posedge clk); #1;
      if (f) begin
        pushes++; fwd_data = rand_vec(); fwd_apply = 1'($urandom); fwd_valid = (pushes < 12);
      end
      if (b) begin pops++; bwd_grad = rand_vec(); bwd_valid = (pops < 12); end
      out_ready = ($urandom_range(3) != 0);
      cyc++;
    end
    check("t5_all_transferred", (pushes == 12 && pops == 12), 1);
    fwd_valid = 1'b0; bwd_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk); #1;

    // Flush overrides same-cycle push and pop
    repeat (6) drive_fwd(rand_vec(), 1'b1);
    out_ready = 1'b0;
    drive_bwd(rand_vec());
    check("t6_pre_count", mask_count, 5);
    check("t6_pre_valid", out_valid, 1);
    flush = 1'b1; out_ready = 1'b1; fwd_valid = 1'b1; bwd_valid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    flush = 1'b0; fwd_valid = 1'b0; bwd_valid = 1'b0;
    check("t6_flush_count", mask_count, 0);
    check("t6_flush_valid", out_valid, 0);
    check("t6_flush_bwd_ready", bwd_ready, 0);
    check("t6_flush_grad", out_grad, 0);

    // Asynchronous reset mid-stream
    repeat (3) drive_fwd(rand_vec(), 1'b1);
    out_ready = 1'b0;
    drive_bwd(rand_vec());
    #3 rst_n = 1'b0;
    #1;
    check("t7_rst_valid", out_valid, 0);
    check("t7_rst_count", mask_count, 0);
    check("t7_rst_grad", out_grad, 0);
    @(posedge clk); #1 rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check("t7_rel_fwd_ready", fwd_ready, 1);
    check("t7_rel_bwd_ready", bwd_ready, 0);
    @(posedge clk); #1;
    drive_fwd(rand_vec(), 1'b1);
    drive_bwd(rand_vec());
    repeat (2) @(posedge clk); #1;
    check("end_exp_empty", exp_q.size(), 0);
    check("end_mask_empty", mask_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
